// File: rtl/counter_multicycle_down_if.sv
// Load/decrement bus for counter_multicycle_down.
// The master drives the load request and the decrement amount.
// The slave (the counter) returns the handshake, the count and the status flags.
interface counter_multicycle_down_if #(
    parameter int NUM_BITS = 64
);
    logic                load_valid;
    logic [NUM_BITS-1:0] load_value;
    logic                load_ready;
    logic [NUM_BITS-1:0] decr_by;
    logic [NUM_BITS-1:0] value;
    logic                busy;
    logic                expired;

    modport master (
        output load_valid, load_value, decr_by,
        input  load_ready, value, busy, expired
    );

    modport slave (
        input  load_valid, load_value, decr_by,
        output load_ready, value, busy, expired
    );
endinterface

// File: rtl/counter_multicycle_down.sv
// Wide down-counter whose subtraction is split across two cycles.
// Stage 1 subtracts decr_by from a low-half shadow register and captures the borrow.
// Stage 2 moves that low half into value and applies the borrow to the high half.
// Together the two stages keep the carry chain at HALF_BITS wide.
// An underflow never reaches the outputs: on expiry the counter forces value to 0
// and enters DONE.
// Optional macro COUNTER_MULTICYCLE_DOWN_CHECK_EN adds a simulation-only check.
// The check fires when decr_by has nonzero upper-half bits during a countdown.
module counter_multicycle_down #(
    parameter int NUM_BITS = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    counter_multicycle_down_if.slave   bus
);
    localparam int HALF_BITS = NUM_BITS / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [NUM_BITS-1:0]  value, value_next;
    logic [HALF_BITS-1:0] low_half, low_half_next;
    logic                 borrow, borrow_next;

    logic [HALF_BITS-1:0] decr_lo;
    logic [HALF_BITS-1:0] value_hi;
    logic                 expiry;

    assign decr_lo  = bus.decr_by[HALF_BITS-1:0];
    assign value_hi = value[NUM_BITS-1:HALF_BITS];

    // Expiry is judged on the registered count, before the next subtraction.
    // A pending borrow into an already-zero high half means the count went negative.
    assign expiry = (value == '0) || (borrow && (value_hi == '0));

    // Next-state and datapath: load from IDLE/DONE, two-stage subtract in RUN.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_next    = state;
        value_next    = value;
        low_half_next = low_half;
        borrow_next   = borrow;

        case (state)
            IDLE, DONE: begin
                if (bus.load_valid) begin
                    state_next    = RUN;
                    value_next    = bus.load_value;
                    low_half_next = bus.load_value[HALF_BITS-1:0];
                    borrow_next   = 1'b0;
                end
            end
            RUN: begin
                if (expiry) begin
                    state_next    = DONE;
                    value_next    = '0;
                    low_half_next = '0;
                    borrow_next   = 1'b0;
                end else begin
                    {borrow_next, low_half_next} = {1'b0, low_half} - {1'b0, decr_lo};
                    value_next = {value_hi - {{(HALF_BITS-1){1'b0}}, borrow}, low_half};
                end
            end
            default: begin
                state_next    = IDLE;
                value_next    = '0;
                low_half_next = '0;
                borrow_next   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; synchronous reset wins over load and expiry.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            value    <= '0;
            low_half <= '0;
            borrow   <= 1'b0;
        end else begin
            state    <= state_next;
            value    <= value_next;
            low_half <= low_half_next;
            borrow   <= borrow_next;
        end
    end

    assign bus.load_ready = (state != RUN);
    assign bus.busy       = (state == RUN);
    assign bus.expired    = (state == DONE);
    assign bus.value      = value;

`ifdef COUNTER_MULTICYCLE_DOWN_CHECK_EN
    // Stop simulation if a countdown is fed a decrement the datapath would truncate.
    always @(posedge clk) begin
        if (!reset && state == RUN && bus.decr_by[NUM_BITS-1:HALF_BITS] != '0) begin
            $fatal(1, "counter_multicycle_down: decr_by upper half nonzero in RUN (0x%0h)",
                   bus.decr_by);
        end
    end
`else
    // The upper half of decr_by is deliberately ignored; fold it into a dangling net.
    logic unused_decr_hi;
    assign unused_decr_hi = ^bus.decr_by[NUM_BITS-1:HALF_BITS];
`endif

endmodule

// File: doc/counter_multicycle_down.md
COUNTER_MULTICYCLE_DOWN -- requirements
Module: counter_multicycle_down

Interface
REQ-001 SHALL have parameter NUM_BITS, default 64, total counter width; even, >= 4; HALF_BITS = NUM_BITS/2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load_valid  input  1  request to load a new countdown value.
REQ-005 SHALL have port load_value  input  NUM_BITS  initial countdown value.
REQ-006 SHALL have port load_ready  output  1  load accepted when load_valid && load_ready at a clock edge.
REQ-007 SHALL have port decr_by  input  NUM_BITS  per-cycle decrement; only the low HALF_BITS are used.
REQ-008 SHALL have port value  output  NUM_BITS  registered count, one cycle behind the stage-1 low half.
REQ-009 SHALL have port busy  output  1  high in RUN.
REQ-010 SHALL have port expired  output  1  high in DONE.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE; load_ready = (state != RUN), busy = (state == RUN), expired = (state == DONE), all derived from registered state.
REQ-012 SHALL, on load accept in IDLE or DONE: set value <= load_value, low_half <= load_value low half, borrow <= 0 and state <= RUN.
REQ-013 SHALL, in RUN with no expiry, perform stage 1: {borrow, low_half} <= low_half - decr_by[HALF_BITS-1:0], where borrow = 1 iff the subtrahend exceeds low_half and low_half wraps modulo 2^HALF_BITS.
REQ-014 SHALL, in the same RUN cycle, perform stage 2: value low half <= low_half (pre-edge value) and value high half <= value high half - borrow (pre-edge borrow).
REQ-015 SHALL define expiry E, evaluated in RUN on pre-edge registers, as (value == 0) || (borrow && value high half == 0).
REQ-016 SHALL, when E is true at an edge, set state <= DONE, value <= 0, low_half <= 0 and borrow <= 0, overriding REQ-013/REQ-014.
REQ-017 SHALL never present a wrapped negative count on value; an underflow saturates to 0 through REQ-016.
REQ-018 SHALL ignore decr_by outside RUN and hold value, low_half and borrow there.
REQ-019 SHALL ignore load_valid while in RUN; there is no abort other than reset.
REQ-020 SHALL hold DONE, with expired = 1 and value = 0, until a load is accepted; expired SHALL deassert the cycle after that accept.
REQ-021 SHALL, on a load of 0, show value = 0 after the accept edge and enter DONE at the following edge.

Reset
REQ-022 SHALL, while reset is high at an edge, set state <= IDLE, value <= 0, low_half <= 0 and borrow <= 0, taking priority over load and expiry including mid-RUN.
REQ-023 SHALL drive load_ready = 1, busy = 0, expired = 0 and value = 0 after reset.

Configuration
REQ-024 SHALL, with COUNTER_MULTICYCLE_DOWN_CHECK_EN defined, include a simulation-only check that calls $fatal when !reset, state == RUN and decr_by upper half != 0.
REQ-025 SHALL, without COUNTER_MULTICYCLE_DOWN_CHECK_EN, omit the check and silently ignore the decr_by upper half, with identical synthesized logic.

Verification
REQ-026 SHALL cover: load 100, decr_by 10 constant -> value 100,100,90,...,10,0 on edges 0..11, DONE/expired = 1 after edge 12.
REQ-027 SHALL cover: load 0x1_0000_0005, decr_by 6 -> after edge 1 low_half = 0xFFFFFFFF with borrow = 1; after edge 2 value = 0x0000_0000_FFFF_FFFF and no expiry.
REQ-028 SHALL cover: load 3, decr_by 5 -> after edge 1 value = 3 and borrow = 1; at edge 2 expiry, with value = 0 and expired = 1, no 0xFFFF... ever visible.
REQ-029 SHALL cover: load 0 -> value = 0 after edge 0, expired = 1 after edge 1; load_valid held in RUN is never accepted.
REQ-030 SHALL cover: load 1000, decr_by 1, reset at cycle 5 -> next edge gives value = 0, load_ready = 1, busy = 0, expired = 0; a new load of 7 then runs normally.
REQ-031 SHALL cover: decr_by = 0x1_0000_0000 in RUN -> $fatal with COUNTER_MULTICYCLE_DOWN_CHECK_EN; without it, value stays constant.
